// File: rtl/start_done_ctrl.sv
// -----------------------------------------------------------------------------
// start_done_ctrl
//
// Single-transaction command sequencer. A command word is accepted through an
// input valid/ready handshake and a one-cycle `start` pulse is issued in the
// same cycle. Exactly LATENCY cycles after the start cycle, a one-cycle `done`
// pulse is issued, and the captured word is presented on an output
// valid/ready handshake. The result is held until the downstream side
// accepts it.
//
// Parameters:
//   DATA_W   - command/result word width
//   LATENCY  - cycles from the start-high cycle to the done-high cycle (1..15)
//
// Ports:
//   clk        - clock, all logic on posedge
//   rst        - synchronous active-high reset
//   in_valid   - command present
//   in_ready   - block can accept a command (high only when idle)
//   in_data    - command word
//   start      - one-cycle pulse, first cycle of a transaction
//   done       - one-cycle pulse, LATENCY cycles after start
//   out_valid  - result available (done cycle and every held cycle)
//   out_ready  - downstream accepts the result
//   out_data   - captured command word of the current transaction
//   out_tag    - 4-bit sequence number, +1 per accepted command, wraps
//   busy       - high in every state except idle
//   txn_cnt    - count of completed output handshakes, wraps at 256
// -----------------------------------------------------------------------------
module start_done_ctrl #(
  parameter int DATA_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              start,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_tag,
  output logic              busy,
  output logic [7:0]        txn_cnt
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;

  // The counter is loaded with LATENCY-1 on acceptance; it is examined in the
  // start cycle and in every wait cycle, so done lands LATENCY cycles later.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       accept;
  logic       handshake;

  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    handshake = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          cnt_nxt   = CNT_LOAD;
          state_nxt = START;
        end
      end
      START, WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt   = cnt - 4'd1;
          state_nxt = WAIT;
        end
      end
      DONE: begin
        if (out_ready) begin
          handshake = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          handshake = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered by decoding the next state, so each flag is valid
  // in the same cycle the FSM enters the corresponding state. DONE is never
  // re-entered from itself, which keeps done to a single cycle, and START and
  // DONE are distinct states, so start and done can never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      in_ready  <= 1'b1;
      start     <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
      out_tag   <= 4'd0;
      txn_cnt   <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values; blocking here would create order-dependent simulation races.
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      in_ready  <= (state_nxt == IDLE);
      start     <= (state_nxt == START);
      done      <= (state_nxt == DONE);
      out_valid <= (state_nxt == DONE) || (state_nxt == HOLD);
      busy      <= (state_nxt != IDLE);
      if (accept) begin
        out_data <= in_data;
        out_tag  <= out_tag + 4'd1;
      end
      if (handshake) begin
        txn_cnt <= txn_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_start_done_ctrl.sv
// -----------------------------------------------------------------------------
// tb_start_done_ctrl
//
// Bench for start_done_ctrl. A LATENCY=2 instance is driven by a table of
// per-edge vectors, a back-to-back tag-wrap sequence and a randomized phase
// compared against a transaction-level reference model with protocol checks.
// A LATENCY=1 instance exercises the shortest latency.
// Output vectors are packed as {in_ready, start, done, out_valid, busy,
// out_data[7:0], out_tag[3:0], txn_cnt[7:0]}.
// -----------------------------------------------------------------------------
module tb_start_done_ctrl;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;
  logic       in_ready, start, done, out_valid, busy;
  logic [7:0] out_data, txn_cnt;
  logic [3:0] out_tag;

  logic       in_valid1 = 1'b0;
  logic [7:0] in_data1 = 8'h00;
  logic       out_ready1 = 1'b0;
  logic       in_ready1, start1, done1, out_valid1, busy1;
  logic [7:0] out_data1, txn_cnt1;
  logic [3:0] out_tag1;

  always #5 clk = ~clk;

  start_done_ctrl #(.DATA_W(8), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .start(start), .done(done), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .busy(busy), .txn_cnt(txn_cnt)
  );

  start_done_ctrl #(.DATA_W(8), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .start(start1), .done(done1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_data(out_data1), .out_tag(out_tag1),
    .busy(busy1), .txn_cnt(txn_cnt1)
  );

  logic [24:0] dut_vec, dut1_vec;
  assign dut_vec  = {in_ready, start, done, out_valid, busy, out_data, out_tag, txn_cnt};
  assign dut1_vec = {in_ready1, start1, done1, out_valid1, busy1, out_data1, out_tag1, txn_cnt1};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [24:0] pack(bit ir, bit st, bit dn, bit ov, bit bz,
                                       logic [7:0] dat, logic [3:0] tg, logic [7:0] tx);
    return {ir, st, dn, ov, bz, dat, tg, tx};
  endfunction

  // ---------------------------------------------------------------------------
  // Transaction-level reference model: one transaction is either absent or
  // identified by the cycle in which it was accepted. All output flags follow
  // from the distance between the current cycle and that acceptance cycle.
  // ---------------------------------------------------------------------------
  int         m_cyc  = 0;
  bit         m_busy = 1'b0;
  int         m_acc  = 0;
  logic [7:0] m_data = 8'h00;
  logic [3:0] m_tag  = 4'h0;
  logic [7:0] m_txn  = 8'h00;

  task automatic model_edge();
    bit result_up;
    result_up = m_busy && ((m_cyc - m_acc) >= LAT);
    if (rst) begin
      m_busy = 1'b0;
      m_data = 8'h00;
      m_tag  = 4'h0;
      m_txn  = 8'h00;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1'b1;
        m_acc  = m_cyc + 1;
        m_data = in_data;
        m_tag  = m_tag + 4'h1;
      end
    end else if (result_up && out_ready) begin
      m_busy = 1'b0;
      m_txn  = m_txn + 8'h01;
    end
    m_cyc++;
  endtask

  function automatic logic [24:0] model_vec();
    bit st, dn, ov;
    st = m_busy && (m_cyc == m_acc);
    dn = m_busy && (m_cyc == m_acc + LAT);
    ov = m_busy && (m_cyc >= m_acc + LAT);
    return pack(!m_busy, st, dn, ov, m_busy, m_data, m_tag, m_txn);
  endfunction

  // One clock edge; the model sees the inputs that the DUT samples, and
  // outputs are compared 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        iv;
    logic [7:0]  d;
    logic        ordy;
    logic [24:0] exp;
  } vec_t;

  function automatic vec_t row(bit r, bit iv, logic [7:0] d, bit ordy,
                               bit ir, bit st, bit dn, bit ov, bit bz,
                               logic [7:0] dat, logic [3:0] tg, logic [7:0] tx);
    vec_t v;
    v.rst  = r;
    v.iv   = iv;
    v.d    = d;
    v.ordy = ordy;
    v.exp  = pack(ir, st, dn, ov, bz, dat, tg, tx);
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    int         last_start;
    int         w;
    int         pend;
    bit         prev_ov;
    bit         edge_rst;
    logic [7:0] prev_data;

    // Inputs of row k are sampled at edge k; expectations are for cycle k.
    //                r iv  d     or   ir st dn ov bz  data   tag   txn
    tbl.push_back(row(1, 0, 8'h00, 0,  1, 0, 0, 0, 0, 8'h00, 4'h0, 8'h00));
    tbl.push_back(row(1, 0, 8'h00, 0,  1, 0, 0, 0, 0, 8'h00, 4'h0, 8'h00));
    // single command, out_ready high
    tbl.push_back(row(0, 1, 8'hA5, 1,  0, 1, 0, 0, 1, 8'hA5, 4'h1, 8'h00));
    tbl.push_back(row(0, 0, 8'h00, 1,  0, 0, 0, 0, 1, 8'hA5, 4'h1, 8'h00));
    tbl.push_back(row(0, 0, 8'h00, 1,  0, 0, 1, 1, 1, 8'hA5, 4'h1, 8'h00));
    tbl.push_back(row(0, 0, 8'h00, 1,  1, 0, 0, 0, 0, 8'hA5, 4'h1, 8'h01));
    // backpressure: out_ready low for 3 cycles after done, in_valid ignored
    tbl.push_back(row(0, 1, 8'h3C, 0,  0, 1, 0, 0, 1, 8'h3C, 4'h2, 8'h01));
    tbl.push_back(row(0, 0, 8'h00, 0,  0, 0, 0, 0, 1, 8'h3C, 4'h2, 8'h01));
    tbl.push_back(row(0, 0, 8'h00, 0,  0, 0, 1, 1, 1, 8'h3C, 4'h2, 8'h01));
    tbl.push_back(row(0, 1, 8'hFF, 0,  0, 0, 0, 1, 1, 8'h3C, 4'h2, 8'h01));
    tbl.push_back(row(0, 1, 8'hFF, 0,  0, 0, 0, 1, 1, 8'h3C, 4'h2, 8'h01));
    tbl.push_back(row(0, 1, 8'hFF, 0,  0, 0, 0, 1, 1, 8'h3C, 4'h2, 8'h01));
    tbl.push_back(row(0, 0, 8'h00, 1,  1, 0, 0, 0, 0, 8'h3C, 4'h2, 8'h02));
    tbl.push_back(row(0, 0, 8'h00, 0,  1, 0, 0, 0, 0, 8'h3C, 4'h2, 8'h02));
    // reset in the cycle after start, with in_valid also high
    tbl.push_back(row(0, 1, 8'h77, 0,  0, 1, 0, 0, 1, 8'h77, 4'h3, 8'h02));
    tbl.push_back(row(0, 0, 8'h00, 0,  0, 0, 0, 0, 1, 8'h77, 4'h3, 8'h02));
    tbl.push_back(row(1, 1, 8'h99, 0,  1, 0, 0, 0, 0, 8'h00, 4'h0, 8'h00));
    tbl.push_back(row(1, 1, 8'h99, 0,  1, 0, 0, 0, 0, 8'h00, 4'h0, 8'h00));
    tbl.push_back(row(0, 0, 8'h00, 0,  1, 0, 0, 0, 0, 8'h00, 4'h0, 8'h00));
    // new command after reset completes normally with tag 1
    tbl.push_back(row(0, 1, 8'h5A, 1,  0, 1, 0, 0, 1, 8'h5A, 4'h1, 8'h00));
    tbl.push_back(row(0, 0, 8'h00, 1,  0, 0, 0, 0, 1, 8'h5A, 4'h1, 8'h00));
    tbl.push_back(row(0, 0, 8'h00, 1,  0, 0, 1, 1, 1, 8'h5A, 4'h1, 8'h00));
    tbl.push_back(row(0, 0, 8'h00, 1,  1, 0, 0, 0, 0, 8'h5A, 4'h1, 8'h01));

    foreach (tbl[i]) begin
      rst       = tbl[i].rst;
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].d;
      out_ready = tbl[i].ordy;
      step();
      check($sformatf("vec%0d", i), {7'd0, dut_vec}, {7'd0, tbl[i].exp});
    end

    // LATENCY=1 instance: start in cycle n, done in cycle n+1, never together
    in_valid1  = 1'b1;
    in_data1   = 8'h42;
    out_ready1 = 1'b1;
    step();
    check("l1_start", {7'd0, dut1_vec}, {7'd0, pack(0, 1, 0, 0, 1, 8'h42, 4'h1, 8'h00)});
    in_valid1 = 1'b0;
    step();
    check("l1_done", {7'd0, dut1_vec}, {7'd0, pack(0, 0, 1, 1, 1, 8'h42, 4'h1, 8'h00)});
    step();
    check("l1_idle", {7'd0, dut1_vec}, {7'd0, pack(1, 0, 0, 0, 0, 8'h42, 4'h1, 8'h01)});

    // Back-to-back: 17 commands with data 0..16, tag wraps 15 -> 0
    rst = 1'b1;
    step();
    rst        = 1'b0;
    last_start = 0;
    for (int i = 0; i < 17; i++) begin
      in_data   = 8'(i);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step();
      w = 0;
      while (!start && w < 8) begin
        step();
        w++;
      end
      check($sformatf("b2b_start%0d", i), {31'd0, start}, 32'd1);
      check($sformatf("b2b_data%0d", i), {24'd0, out_data}, 32'(i));
      check($sformatf("b2b_tag%0d", i), {28'd0, out_tag}, 32'((i + 1) % 16));
      if (i > 0) check($sformatf("b2b_gap%0d", i), 32'(m_cyc - last_start), 32'(LAT + 2));
      last_start = m_cyc;
    end
    in_valid = 1'b0;
    repeat (4) step();
    check("b2b_txn", {24'd0, txn_cnt}, 32'd17);
    check("b2b_final_tag", {28'd0, out_tag}, 32'd1);

    // Randomized phase against the reference model plus protocol properties
    rst = 1'b1;
    step();
    rst       = 1'b0;
    pend      = -1;
    prev_ov   = 1'b0;
    prev_data = out_data;
    for (int i = 0; i < 1000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = $urandom_range(0, 1) == 1;
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = 8'($urandom);
      edge_rst  = rst;
      step();
      check("rand_model", {7'd0, dut_vec}, {7'd0, model_vec()});
      if (edge_rst) begin
        pend = -1;
      end else begin
        if (pend >= 0 && m_cyc == pend + LAT) begin
          check("start_to_done", {31'd0, done}, 32'd1);
          pend = -1;
        end
        if (prev_ov && !out_ready)
          check("hold_stable", {23'd0, out_valid, out_data}, {23'd0, 1'b1, prev_data});
      end
      if (start) pend = m_cyc;
      if (done) check("done_has_valid", {31'd0, out_valid}, 32'd1);
      if (out_valid && !prev_ov) check("valid_rise_done", {31'd0, done}, 32'd1);
      check("start_done_apart", {31'd0, start & done}, 32'd0);
      prev_ov   = out_valid;
      prev_data = out_data;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/start_done_ctrl.md
# start_done_ctrl

Command sequencer that drives the `start` / `done` / `valid` / `ready` signals checked by the multiple-sequence SVA bench. It accepts one command word through an input valid/ready handshake and emits a one-cycle `start` pulse. Exactly `LATENCY` cycles later it emits a one-cycle `done` pulse, together with a result word held on an output valid/ready handshake. It sits directly upstream of the start→done protocol checker and produces the traffic that checker samples.

## Interface
Parameters:
- `DATA_W`, 8, width of command/result data.
- `LATENCY`, 2, cycles from the `start`-high cycle to the `done`-high cycle. Legal range 1..15.

Ports:
- `clk`, in, 1, sole clock; all logic on posedge.
- `rst`, in, 1, synchronous, active-high reset.
- `in_valid`, in, 1, command present.
- `in_ready`, out, 1, block can accept a command.
- `in_data`, in, `DATA_W`, command word.
- `start`, out, 1, one-cycle pulse marking the start of a transaction.
- `done`, out, 1, one-cycle pulse marking the end of a transaction.
- `out_valid`, out, 1, result available.
- `out_ready`, in, 1, downstream accepts the result.
- `out_data`, out, `DATA_W`, result word, equal to the captured `in_data`.
- `out_tag`, out, 4, sequence number of the transaction.
- `busy`, out, 1, high whenever state ≠ IDLE.
- `txn_cnt`, out, 8, count of completed output handshakes.

## Operation
- FSM states: IDLE, START, WAIT, DONE, HOLD. All outputs are registered.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready` at a posedge: capture `in_data`, load the down-counter with `LATENCY-1`, go to START.
- START:
  - `start`=1 for this single cycle.
  - If counter==0 (only when `LATENCY`=1), go to DONE; else decrement and go to WAIT.
- WAIT:
  - While counter≠0, decrement each cycle and stay in WAIT.
  - When counter==0, go to DONE.
- DONE:
  - `done`=1 and `out_valid`=1 for this cycle.
  - If `out_ready`=1, the handshake completes: increment `txn_cnt` and go to IDLE.
  - Else go to HOLD.
- HOLD:
  - `out_valid`=1 and `done`=0.
  - `out_data` and `out_tag` are held stable.
  - On `out_ready`=1, increment `txn_cnt` and go to IDLE.
- `out_tag` increments by 1 on every accepted command and wraps 15→0. `out_data`/`out_tag` show the value of the current transaction from START onward.
- `txn_cnt` wraps 255→0 with no saturation and no error flag.
- Only one transaction is in flight; `in_ready`=0 in every state except IDLE. `in_valid` while busy is ignored, not queued.
- `start` and `done` are never high in the same cycle, including when `LATENCY`=1.
- `out_ready` outside DONE/HOLD is ignored.
- Reset values: `in_ready`=1, `start`=0, `done`=0, `out_valid`=0, `out_data`=0, `out_tag`=0, `busy`=0, `txn_cnt`=0, state=IDLE.

## Timing
- Cycle n is the interval following posedge n.
- Command accepted at posedge n → `start`=1 in cycle n.
- `done`=1 and `out_valid` rises in cycle n+`LATENCY`. Seen by a sampler, `start` at edge k implies `done` at edge k+`LATENCY`, which is `start ##2 done` at the default.
- `out_valid`=1 in the `done` cycle guarantees the downstream `valid` term of `valid && ready` holds whenever `done` is sampled.
- Zero-stall throughput: one transaction per `LATENCY`+2 cycles. Next acceptance is earliest at posedge n+`LATENCY`+2.
- `rst` asserted in any state: all outputs take reset values at the next posedge. The in-flight transaction is dropped with no `done` and no `txn_cnt` increment. `rst` has priority over a simultaneous `in_valid` or `out_ready`.
- `in_valid` and `rst` both high: the command is not accepted.

## Test plan
- Reset then single command: `in_data`=0xA5 accepted at edge 2, `out_ready`=1 → `start`=1 cycle 2 only; `done`=1 and `out_valid`=1 cycle 4 only; `out_data`=0xA5, `out_tag`=1, `txn_cnt`=1; `in_ready` back to 1 in cycle 5.
- Backpressure: as above with `out_ready`=0 for 3 cycles after `done` → `done` pulses exactly once; `out_valid` stays high 4 cycles; `out_data` stable; `in_valid`=1 during HOLD is not accepted; `txn_cnt` increments only on the `out_ready` edge.
- `LATENCY`=1 build: command at edge n → `start` in cycle n, `done` in cycle n+1, never coincident.
- Back-to-back 17 commands with `out_ready`=1, data 0..16 → commands spaced 4 cycles apart; `out_tag` runs 1..15, 0, 1 (wrap); `txn_cnt`=17.
- Reset mid-operation: `rst` high in the cycle after `start` → next cycle all outputs at reset values, no `done` ever appears, `txn_cnt` unchanged at 0; a new command then completes normally with `out_tag`=1.
- SVA bind: assert `start |-> ##LATENCY done`, `done |-> out_valid`, `$rose(out_valid) |-> done`, and `out_valid && !out_ready |=> $stable(out_data) && out_valid` over 1000 random `in_valid`/`out_ready` cycles → zero failures.
